sram_wb_port0_bridge: RTL and testbench

Wishbone classic slave that turns processor bus cycles into single accesses on port 0 (RW) of the 32x512 OpenRAM macro. It sits directly upstream of the macro and drives all port-0 control, address, data and mask inputs from registers. It times read-data capture to the macro's register-on-posedge / act-on-negedge protocol. The integrator ties the macro's clk0 to wb_clk_i.

---
 rtl/sram_wb_port0_bridge.sv | 91 +++++++++
 tb/tb_sram_wb_port0_bridge.sv | 393 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sram_wb_port0_bridge.sv
// Wishbone classic slave driving port 0 (RW) of a 32x512 OpenRAM macro.
// Each access walks IDLE -> ACCESS -> WAIT -> ACK to fit the macro's posedge-register / negedge-act timing.
module sram_wb_port0_bridge #(
   parameter logic [31:0] BASE_ADDR  = 32'h3000_0000,
   parameter int          ADDR_WIDTH = 9,
   parameter int          DATA_WIDTH = 32,
   parameter int          NUM_WMASKS = 4
) (
   input  logic                  wb_clk_i,
   input  logic                  wb_rst_i,
   input  logic                  wbs_cyc_i,
   input  logic                  wbs_stb_i,
   input  logic                  wbs_we_i,
   input  logic [NUM_WMASKS-1:0] wbs_sel_i,
   input  logic [31:0]           wbs_adr_i,
   input  logic [DATA_WIDTH-1:0] wbs_dat_i,
   output logic                  wbs_ack_o,
   output logic [DATA_WIDTH-1:0] wbs_dat_o,
   output logic                  sram_csb0,
   output logic                  sram_web0,
   output logic [NUM_WMASKS-1:0] sram_wmask0,
   output logic [ADDR_WIDTH-1:0] sram_addr0,
   output logic [DATA_WIDTH-1:0] sram_din0,
   input  logic [DATA_WIDTH-1:0] sram_dout0
);

   localparam int WIN_LSB = ADDR_WIDTH + 2;

   typedef enum logic [1:0] {IDLE, ACCESS, WAIT, ACK} state_t;

   state_t state;
   logic   is_read;
   logic   aborted;
   logic   req;
   logic   hit;
   logic   unused_adr_bits;

   assign req             = wbs_cyc_i & wbs_stb_i;
   assign hit             = (wbs_adr_i[31:WIN_LSB] == BASE_ADDR[31:WIN_LSB]);
   assign unused_adr_bits = ^wbs_adr_i[1:0];

   // NOTE: every register here uses <= so all updates on an edge see the pre-edge values.
   always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
      if (wb_rst_i) begin
         state       <= IDLE;
         is_read     <= 1'b0;
         aborted     <= 1'b0;
         sram_csb0   <= 1'b1;
         sram_web0   <= 1'b1;
         sram_wmask0 <= '0;
         sram_addr0  <= '0;
         sram_din0   <= '0;
         wbs_ack_o   <= 1'b0;
         wbs_dat_o   <= '0;
      end else begin
         wbs_ack_o <= 1'b0;
         case (state)
            IDLE: begin
               if (req && hit) begin
                  state       <= ACCESS;
                  is_read     <= ~wbs_we_i;
                  aborted     <= 1'b0;
                  sram_csb0   <= 1'b0;
                  sram_web0   <= ~wbs_we_i;
                  sram_addr0  <= wbs_adr_i[WIN_LSB-1:2];
                  sram_din0   <= wbs_dat_i;
                  sram_wmask0 <= wbs_we_i ? wbs_sel_i : '0;
               end
            end
            ACCESS: begin
               // The macro has sampled the request on this edge; addr0/din0 stay put.
               state       <= WAIT;
               sram_csb0   <= 1'b1;
               sram_web0   <= 1'b1;
               sram_wmask0 <= '0;
               if (!req) aborted <= 1'b1;
            end
            WAIT: begin
               state <= ACK;
               if (is_read) wbs_dat_o <= sram_dout0;
               wbs_ack_o <= req & ~aborted;
            end
            ACK: begin
               state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_sram_wb_port0_bridge.sv
// Randomised self-checking bench for sram_wb_port0_bridge with a behavioural macro model
// and an array-based reference of the expected memory contents.
module tb_sram_wb_port0_bridge;

   localparam logic [31:0] BASE = 32'h3000_0000;

   logic        wb_clk_i = 1'b0;
   logic        wb_rst_i = 1'b1;
   logic        wbs_cyc_i = 1'b0;
   logic        wbs_stb_i = 1'b0;
   logic        wbs_we_i = 1'b0;
   logic [3:0]  wbs_sel_i = '0;
   logic [31:0] wbs_adr_i = '0;
   logic [31:0] wbs_dat_i = '0;
   logic        wbs_ack_o;
   logic [31:0] wbs_dat_o;
   logic        sram_csb0;
   logic        sram_web0;
   logic [3:0]  sram_wmask0;
   logic [8:0]  sram_addr0;
   logic [31:0] sram_din0;
   logic [31:0] sram_dout0 = '0;

   int tests_run    = 0;
   int tests_failed = 0;

   sram_wb_port0_bridge dut (
      .wb_clk_i   (wb_clk_i),
      .wb_rst_i   (wb_rst_i),
      .wbs_cyc_i  (wbs_cyc_i),
      .wbs_stb_i  (wbs_stb_i),
      .wbs_we_i   (wbs_we_i),
      .wbs_sel_i  (wbs_sel_i),
      .wbs_adr_i  (wbs_adr_i),
      .wbs_dat_i  (wbs_dat_i),
      .wbs_ack_o  (wbs_ack_o),
      .wbs_dat_o  (wbs_dat_o),
      .sram_csb0  (sram_csb0),
      .sram_web0  (sram_web0),
      .sram_wmask0(sram_wmask0),
      .sram_addr0 (sram_addr0),
      .sram_din0  (sram_din0),
      .sram_dout0 (sram_dout0)
   );

   always #5 wb_clk_i = ~wb_clk_i;

   // Macro model: inputs registered on posedge, operation performed on negedge.
   logic [31:0] mem [512];
   logic        m_csb = 1'b1;
   logic        m_web = 1'b1;
   logic [3:0]  m_wmask = '0;
   logic [8:0]  m_addr = '0;
   logic [31:0] m_din = '0;
   logic [31:0] m_word;

   always @(posedge wb_clk_i) begin
      m_csb   <= sram_csb0;
      m_web   <= sram_web0;
      m_wmask <= sram_wmask0;
      m_addr  <= sram_addr0;
      m_din   <= sram_din0;
   end

   always @(negedge wb_clk_i) begin
      if (!m_csb) begin
         if (!m_web) begin
            m_word = mem[m_addr];
            for (int b = 0; b < 4; b++)
               if (m_wmask[b]) m_word[8*b +: 8] = m_din[8*b +: 8];
            mem[m_addr] <= m_word;
         end else begin
            sram_dout0 <= mem[m_addr];
         end
      end
   end

   // Mid-cycle activity counters: cycles with chip select low, cycles with ack high.
   int csb_lo = 0;
   int ack_hi = 0;
   always @(negedge wb_clk_i) begin
      if (sram_csb0 === 1'b0) csb_lo++;
      if (wbs_ack_o === 1'b1) ack_hi++;
   end

   // Reference: expected memory contents after every completed write.
   logic [31:0] ref_mem [512];

   // Port-0 values seen in the first cycle after the request was sampled.
   logic        acc_csb;
   logic        acc_web;
   logic [3:0]  acc_wmask;
   logic [8:0]  acc_addr;
   logic [31:0] acc_din;

   task automatic ref_write(input int word, input logic [3:0] sel, input logic [31:0] dat);
      for (int b = 0; b < 4; b++)
         if (sel[b]) ref_mem[word][8*b +: 8] = dat[8*b +: 8];
   endtask

   task automatic idle(input int n);
      repeat (n) begin
         @(posedge wb_clk_i);
         #1;
      end
   endtask

   task automatic wb_xfer(input logic we, input logic [3:0] sel, input logic [31:0] adr,
                          input logic [31:0] dat, input bit keep,
                          output logic [31:0] rdata, output int cycles, output bit acked);
      wbs_cyc_i = 1'b1;
      wbs_stb_i = 1'b1;
      wbs_we_i  = we;
      wbs_sel_i = sel;
      wbs_adr_i = adr;
      wbs_dat_i = dat;
      cycles = 0;
      acked  = 1'b0;
      rdata  = 'x;
      while (!acked && cycles < 20) begin
         @(posedge wb_clk_i);
         #1;
         cycles++;
         if (cycles == 1) begin
            acc_csb   = sram_csb0;
            acc_web   = sram_web0;
            acc_wmask = sram_wmask0;
            acc_addr  = sram_addr0;
            acc_din   = sram_din0;
         end
         if (wbs_ack_o === 1'b1) begin
            acked = 1'b1;
            rdata = wbs_dat_o;
         end
      end
      if (!keep) begin
         wbs_cyc_i = 1'b0;
         wbs_stb_i = 1'b0;
         wbs_we_i  = 1'b0;
      end
   endtask

   task automatic test_reset;
      wb_rst_i = 1'b1;
      idle(3);
      tests_run += 7;
      if (sram_csb0 !== 1'b1) begin tests_failed++; $display("FAIL reset_csb0 got %b want 1", sram_csb0); end
      if (sram_web0 !== 1'b1) begin tests_failed++; $display("FAIL reset_web0 got %b want 1", sram_web0); end
      if (sram_wmask0 !== 4'h0) begin tests_failed++; $display("FAIL reset_wmask0 got %h want 0", sram_wmask0); end
      if (sram_addr0 !== 9'h0) begin tests_failed++; $display("FAIL reset_addr0 got %h want 0", sram_addr0); end
      if (sram_din0 !== 32'h0) begin tests_failed++; $display("FAIL reset_din0 got %h want 0", sram_din0); end
      if (wbs_ack_o !== 1'b0) begin tests_failed++; $display("FAIL reset_ack got %b want 0", wbs_ack_o); end
      if (wbs_dat_o !== 32'h0) begin tests_failed++; $display("FAIL reset_dat_o got %h want 0", wbs_dat_o); end
      wb_rst_i = 1'b0;
      idle(1);
   endtask

   // Back-to-back writes of random data to every word so the reference is fully known.
   task automatic fill_memory;
      logic [31:0] rd, dat;
      int cyc;
      bit ok;
      int misses = 0;
      for (int w = 0; w < 512; w++) begin
         dat = $urandom;
         wb_xfer(1'b1, 4'hF, BASE | (w << 2), dat, 1'b1, rd, cyc, ok);
         if (!ok) misses++;
         for (int b = 0; b < 4; b++) ref_mem[w][8*b +: 8] = dat[8*b +: 8];
      end
      wbs_cyc_i = 1'b0;
      wbs_stb_i = 1'b0;
      wbs_we_i  = 1'b0;
      idle(2);
      tests_run++;
      if (misses != 0) begin tests_failed++; $display("FAIL fill_acks got %0d missing acks want 0", misses); end
   endtask

   task automatic test_write_read;
      logic [31:0] rd;
      int cyc, c0;
      bit ok;
      c0 = csb_lo;
      wb_xfer(1'b1, 4'hF, 32'h3000_0010, 32'hDEAD_BEEF, 1'b0, rd, cyc, ok);
      ref_write(4, 4'hF, 32'hDEAD_BEEF);
      idle(3);
      tests_run += 7;
      if (!ok) begin tests_failed++; $display("FAIL wr_ack got no ack want ack"); end
      if (cyc != 3) begin tests_failed++; $display("FAIL wr_latency got %0d want 3", cyc); end
      if (acc_addr !== 9'd4) begin tests_failed++; $display("FAIL wr_addr0 got %0d want 4", acc_addr); end
      if (acc_wmask !== 4'hF) begin tests_failed++; $display("FAIL wr_wmask0 got %h want f", acc_wmask); end
      if (acc_web !== 1'b0 || acc_csb !== 1'b0) begin
         tests_failed++; $display("FAIL wr_ctrl got web0=%b csb0=%b want 0 0", acc_web, acc_csb);
      end
      if (acc_din !== 32'hDEAD_BEEF) begin tests_failed++; $display("FAIL wr_din0 got %h want deadbeef", acc_din); end
      if (csb_lo - c0 != 1) begin tests_failed++; $display("FAIL wr_csb_cycles got %0d want 1", csb_lo - c0); end
      wb_xfer(1'b0, 4'hF, 32'h3000_0010, 32'h0, 1'b0, rd, cyc, ok);
      idle(1);
      tests_run += 2;
      if (!ok) begin tests_failed++; $display("FAIL rd_ack got no ack want ack"); end
      if (rd !== 32'hDEAD_BEEF) begin tests_failed++; $display("FAIL rd_data got %h want deadbeef", rd); end
   endtask

   task automatic test_byte_mask;
      logic [31:0] rd;
      int cyc;
      bit ok;
      wb_xfer(1'b1, 4'hF, BASE | 32'h20, 32'h1122_3344, 1'b0, rd, cyc, ok);
      ref_write(8, 4'hF, 32'h1122_3344);
      idle(1);
      wb_xfer(1'b1, 4'b0101, BASE | 32'h20, 32'hAABB_CCDD, 1'b0, rd, cyc, ok);
      ref_write(8, 4'b0101, 32'hAABB_CCDD);
      idle(1);
      wb_xfer(1'b0, 4'hF, BASE | 32'h20, 32'h0, 1'b0, rd, cyc, ok);
      idle(1);
      tests_run++;
      if (rd !== 32'h11BB_33DD) begin tests_failed++; $display("FAIL mask_0101 got %h want 11bb33dd", rd); end
      // A write with no byte selects is acked but must leave the word intact.
      wb_xfer(1'b1, 4'h0, BASE | 32'h20, 32'hFFFF_FFFF, 1'b0, rd, cyc, ok);
      idle(1);
      tests_run += 2;
      if (!ok) begin tests_failed++; $display("FAIL mask_0000_ack got no ack want ack"); end
      if (acc_wmask !== 4'h0) begin tests_failed++; $display("FAIL mask_0000_wmask got %h want 0", acc_wmask); end
      wb_xfer(1'b0, 4'hF, BASE | 32'h20, 32'h0, 1'b0, rd, cyc, ok);
      idle(1);
      tests_run++;
      if (rd !== ref_mem[8]) begin tests_failed++; $display("FAIL mask_0000_data got %h want %h", rd, ref_mem[8]); end
   endtask

   task automatic test_decode;
      logic [31:0] rd, dat;
      logic [31:0] miss_adr [2];
      int cyc, c0, a0;
      bit ok;
      dat = $urandom;
      wb_xfer(1'b1, 4'hF, 32'h3000_07FC, dat, 1'b0, rd, cyc, ok);
      ref_write(511, 4'hF, dat);
      idle(1);
      tests_run++;
      if (acc_addr !== 9'd511) begin tests_failed++; $display("FAIL decode_top got %0d want 511", acc_addr); end
      wb_xfer(1'b0, 4'hF, 32'h3000_07FC, 32'h0, 1'b0, rd, cyc, ok);
      idle(1);
      tests_run++;
      if (rd !== ref_mem[511]) begin tests_failed++; $display("FAIL decode_top_data got %h want %h", rd, ref_mem[511]); end
      miss_adr[0] = 32'h3000_0800;
      miss_adr[1] = 32'h2FFF_FFFC;
      for (int i = 0; i < 2; i++) begin
         c0 = csb_lo;
         a0 = ack_hi;
         wbs_cyc_i = 1'b1;
         wbs_stb_i = 1'b1;
         wbs_we_i  = i[0];
         wbs_sel_i = 4'hF;
         wbs_adr_i = miss_adr[i];
         idle(10);
         wbs_cyc_i = 1'b0;
         wbs_stb_i = 1'b0;
         idle(1);
         tests_run++;
         if (csb_lo != c0 || ack_hi != a0) begin
            tests_failed++;
            $display("FAIL decode_miss %h got csb=%0d ack=%0d want 0 0", miss_adr[i], csb_lo - c0, ack_hi - a0);
         end
      end
   endtask

   task automatic test_abort;
      logic [31:0] rd;
      int cyc, a0, c0;
      bit ok;
      a0 = ack_hi;
      c0 = csb_lo;
      wbs_cyc_i = 1'b1;
      wbs_stb_i = 1'b1;
      wbs_we_i  = 1'b0;
      wbs_sel_i = 4'hF;
      wbs_adr_i = BASE | 32'h10;
      idle(2);
      wbs_cyc_i = 1'b0;
      wbs_stb_i = 1'b0;
      idle(4);
      tests_run += 3;
      if (ack_hi != a0) begin tests_failed++; $display("FAIL abort_ack got %0d acks want 0", ack_hi - a0); end
      if (csb_lo - c0 != 1) begin tests_failed++; $display("FAIL abort_csb got %0d want 1", csb_lo - c0); end
      if (wbs_dat_o !== ref_mem[4]) begin tests_failed++; $display("FAIL abort_capture got %h want %h", wbs_dat_o, ref_mem[4]); end
      wb_xfer(1'b0, 4'hF, BASE | 32'h14, 32'h0, 1'b0, rd, cyc, ok);
      idle(1);
      tests_run += 2;
      if (!ok || cyc != 3) begin tests_failed++; $display("FAIL abort_next ack=%b latency got %0d want 1 3", ok, cyc); end
      if (rd !== ref_mem[5]) begin tests_failed++; $display("FAIL abort_next_data got %h want %h", rd, ref_mem[5]); end
   endtask

   task automatic test_back_to_back;
      logic [31:0] rd;
      int cyc, c0, a0;
      bit ok;
      c0 = csb_lo;
      a0 = ack_hi;
      for (int w = 0; w < 8; w++) begin
         wb_xfer(1'b0, 4'hF, BASE | (w << 2), 32'h0, 1'b1, rd, cyc, ok);
         tests_run++;
         if (!ok || cyc != (w == 0 ? 3 : 4) || rd !== ref_mem[w]) begin
            tests_failed++;
            $display("FAIL b2b word %0d got ack=%b cycles=%0d data=%h want 1 %0d %h",
                     w, ok, cyc, rd, (w == 0 ? 3 : 4), ref_mem[w]);
         end
      end
      wbs_cyc_i = 1'b0;
      wbs_stb_i = 1'b0;
      idle(3);
      tests_run++;
      if (csb_lo - c0 != 8 || ack_hi - a0 != 8) begin
         tests_failed++;
         $display("FAIL b2b_counts got csb=%0d ack=%0d want 8 8", csb_lo - c0, ack_hi - a0);
      end
   endtask

   task automatic test_random;
      logic [31:0] rd, dat;
      logic [3:0]  sel;
      logic        we;
      int word, cyc;
      bit ok;
      for (int i = 0; i < 60; i++) begin
         we   = $urandom_range(0, 1);
         word = $urandom_range(0, 511);
         sel  = $urandom;
         dat  = $urandom;
         wb_xfer(we, sel, BASE | (word << 2) | $urandom_range(0, 3), dat, 1'b0, rd, cyc, ok);
         if (we) ref_write(word, sel, dat);
         if ($urandom_range(0, 1)) idle(1);
         tests_run++;
         if (!ok || (!we && rd !== ref_mem[word])) begin
            tests_failed++;
            $display("FAIL random #%0d we=%b word=%0d ack=%b got %h want %h", i, we, word, ok, rd, ref_mem[word]);
         end
      end
      idle(1);
   endtask

   task automatic test_reset_mid;
      logic [31:0] rd;
      int cyc;
      bit ok;
      wbs_cyc_i = 1'b1;
      wbs_stb_i = 1'b1;
      wbs_we_i  = 1'b0;
      wbs_sel_i = 4'hF;
      wbs_adr_i = BASE | 32'h18;
      idle(1);
      tests_run++;
      if (sram_csb0 !== 1'b0) begin tests_failed++; $display("FAIL midrst_pre_csb got %b want 0", sram_csb0); end
      #2;
      wb_rst_i  = 1'b1;
      wbs_cyc_i = 1'b0;
      wbs_stb_i = 1'b0;
      #1;
      tests_run += 2;
      if (sram_csb0 !== 1'b1) begin tests_failed++; $display("FAIL midrst_csb got %b want 1", sram_csb0); end
      if (wbs_dat_o !== 32'h0 || wbs_ack_o !== 1'b0) begin
         tests_failed++; $display("FAIL midrst_outputs got dat=%h ack=%b want 0 0", wbs_dat_o, wbs_ack_o);
      end
      idle(1);
      wb_rst_i = 1'b0;
      idle(1);
      wb_xfer(1'b0, 4'hF, BASE | 32'h18, 32'h0, 1'b0, rd, cyc, ok);
      idle(1);
      tests_run++;
      if (!ok || cyc != 3 || rd !== ref_mem[6]) begin
         tests_failed++; $display("FAIL midrst_recover got ack=%b cycles=%0d data=%h want 1 3 %h", ok, cyc, rd, ref_mem[6]);
      end
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog expired before the bench finished");
      $fatal(1, "watchdog");
   end

   initial begin
      test_reset();
      fill_memory();
      test_write_read();
      test_byte_mask();
      test_decode();
      test_abort();
      test_back_to_back();
      test_random();
      test_reset_mid();
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
